// File: rtl/ema_burst_gen.sv
// EMA transducer excitation sequencer: per-frame P/N pulse-pair burst with ON_32 supply window
// and CTRL_SW receive-switch window, in continuous or single-shot mode.
module ema_burst_gen #(
  parameter int CNT_W       = 24,
  parameter int PERIOD      = 16777216,
  parameter int BURST_START = 6400000,
  parameter int HALF_W      = 10,
  parameter int DEAD_W      = 3,
  parameter int NC_W        = 4,
  parameter int ON32_LEAD   = 1,
  parameter int CTRL_TAIL   = 160
) (
  input  logic            clk_80mhz,
  input  logic            rst,
  input  logic            en,
  input  logic            single_shot,
  input  logic            trig,
  input  logic [NC_W-1:0] n_cycles,
  output logic            busy,
  output logic            frame_done,
  output logic            EMA_PULSE_P,
  output logic            EMA_PULSE_N,
  output logic            ON_32,
  output logic            CTRL_SW
);

  localparam int CYC  = 2 * HALF_W + DEAD_W;
  localparam int PH_W = (CYC > 1) ? $clog2(CYC) : 1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] BS_M1    = CNT_W'(BURST_START - 1);
  localparam logic [CNT_W-1:0] LEAD_CNT = CNT_W'(ON32_LEAD);
  localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(HALF_W);
  localparam logic [PH_W-1:0]  PH_N_END = PH_W'(2 * HALF_W - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CYC - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            state_q, state_d;
  logic              load_frame;
  logic [CNT_W-1:0]  cnt_q;
  logic [NC_W-1:0]   nl_q;
  logic [NC_W-1:0]   k_q;
  logic [PH_W-1:0]   ph_q;
  logic              in_burst_q;
  logic              cont_q;
  logic [CNT_W-1:0]  burst_end_q;
  logic [CNT_W-1:0]  ctrl_end_q;
  logic              start_req;
  logic              last_cnt;

  // Window ends for a frame with n pairs; the trailing dead phase of the last pair is not burst.
  function automatic logic [CNT_W-1:0] burst_end_of(input logic [NC_W-1:0] n);
    logic [31:0] e;
    if (n == '0) e = 32'(BURST_START);
    else         e = 32'(BURST_START) + 32'(n) * 32'(CYC) - 32'(DEAD_W);
    return e[CNT_W-1:0];
  endfunction

  assign start_req  = (!single_shot && en) || (single_shot && trig);
  assign last_cnt   = (cnt_q == LAST_CNT);
  assign busy       = (state_q == S_RUN);
  assign frame_done = (state_q == S_RUN) && last_cnt;

  always_comb begin
    state_d    = state_q;
    load_frame = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          state_d    = S_RUN;
          load_frame = 1'b1;
        end
      end
      S_RUN: begin
        if (last_cnt) begin
          if (cont_q && en) load_frame = 1'b1;
          else              state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_80mhz) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      nl_q        <= '0;
      k_q         <= '0;
      ph_q        <= '0;
      in_burst_q  <= 1'b0;
      cont_q      <= 1'b0;
      burst_end_q <= '0;
      ctrl_end_q  <= '0;
      EMA_PULSE_P <= 1'b1;
      EMA_PULSE_N <= 1'b1;
      ON_32       <= 1'b1;
      CTRL_SW     <= 1'b0;
    end else begin
      state_q <= state_d;

      if (load_frame || state_d == S_IDLE) cnt_q <= '0;
      else                                 cnt_q <= cnt_q + CNT_W'(1);

      if (load_frame) begin
        nl_q        <= n_cycles;
        burst_end_q <= burst_end_of(n_cycles);
        ctrl_end_q  <= burst_end_of(n_cycles) + CNT_W'(CTRL_TAIL);
        if (state_q == S_IDLE) cont_q <= !single_shot;
      end

      // ph/k describe the current cnt; the burst ends after the last N phase.
      if (state_q != S_RUN) begin
        in_burst_q <= 1'b0;
        ph_q       <= '0;
        k_q        <= '0;
      end else if (cnt_q == BS_M1) begin
        in_burst_q <= (nl_q != '0);
        ph_q       <= '0;
        k_q        <= '0;
      end else if (in_burst_q) begin
        if (ph_q == PH_N_END && k_q == nl_q - NC_W'(1)) begin
          in_burst_q <= 1'b0;
          ph_q       <= '0;
        end else if (ph_q == PH_LAST) begin
          ph_q <= '0;
          k_q  <= k_q + NC_W'(1);
        end else begin
          ph_q <= ph_q + PH_W'(1);
        end
      end

      if (state_q == S_RUN) begin
        EMA_PULSE_P <= !(in_burst_q && ph_q < PH_HALF);
        EMA_PULSE_N <= !(in_burst_q && ph_q >= PH_HALF && ph_q <= PH_N_END);
        ON_32       <= !(cnt_q >= LEAD_CNT && cnt_q < burst_end_q);
        CTRL_SW     <= (cnt_q >= BS_M1) && (cnt_q < ctrl_end_q);
      end else begin
        EMA_PULSE_P <= 1'b1;
        EMA_PULSE_N <= 1'b1;
        ON_32       <= 1'b1;
        CTRL_SW     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ema_burst_gen.sv
// Self-checking bench for ema_burst_gen: directed scenarios plus random stimulus against an
// arithmetic per-count reference model and a per-frame pulse-count scoreboard.
module tb_ema_burst_gen;

  localparam int CNT_W = 8;
  localparam int PERIOD = 200;
  localparam int BS = 50;
  localparam int H = 10;
  localparam int D = 3;
  localparam int NC_W = 4;
  localparam int LEAD = 1;
  localparam int TAIL = 20;
  localparam int CYC = 2 * H + D;

  // clock/reset
  logic clk_80mhz = 1'b0;
  always #5 clk_80mhz = ~clk_80mhz;

  logic            rst, en, single_shot, trig;
  logic [NC_W-1:0] n_cycles;
  logic            busy, frame_done, EMA_PULSE_P, EMA_PULSE_N, ON_32, CTRL_SW;

  ema_burst_gen #(
    .CNT_W(CNT_W), .PERIOD(PERIOD), .BURST_START(BS), .HALF_W(H), .DEAD_W(D),
    .NC_W(NC_W), .ON32_LEAD(LEAD), .CTRL_TAIL(TAIL)
  ) dut (
    .clk_80mhz(clk_80mhz), .rst(rst), .en(en), .single_shot(single_shot), .trig(trig),
    .n_cycles(n_cycles), .busy(busy), .frame_done(frame_done), .EMA_PULSE_P(EMA_PULSE_P),
    .EMA_PULSE_N(EMA_PULSE_N), .ON_32(ON_32), .CTRL_SW(CTRL_SW)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  bit   m_run = 0;
  bit   m_cont = 0;
  int   m_cnt = 0;
  int   m_nl = 0;
  logic m_p = 1'b1, m_n = 1'b1, m_on = 1'b1, m_ctrl = 1'b0;

  // scoreboard: pairs expected per frame, in frame order
  logic [NC_W-1:0] exp_q[$];
  int   pulse_cnt = 0;
  logic prev_p = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_idle();
    m_p = 1'b1; m_n = 1'b1; m_on = 1'b1; m_ctrl = 1'b0;
  endtask

  // Output value produced from count c of a frame with nl pairs.
  task automatic model_drive(input int c, input int nl);
    int be, pe, off;
    pe  = BS + nl * CYC;
    be  = (nl == 0) ? BS : pe - D;
    off = (c >= BS) ? (c - BS) % CYC : 0;
    m_p    = !(c >= BS && c < pe && off < H);
    m_n    = !(c >= BS && c < pe && off >= H && off < 2 * H);
    m_on   = !(c >= LEAD && c < be);
    m_ctrl = (c >= BS - 1) && (c < be + TAIL);
  endtask

  task automatic model_step();
    if (rst) begin
      m_run = 0; m_cnt = 0; m_nl = 0;
      model_idle();
      exp_q.delete();
      pulse_cnt = 0;
    end else if (!m_run) begin
      model_idle();
      if ((!single_shot && en) || (single_shot && trig)) begin
        m_run = 1; m_cnt = 0; m_nl = int'(n_cycles); m_cont = !single_shot;
        exp_q.push_back(n_cycles);
      end
    end else begin
      model_drive(m_cnt, m_nl);
      if (m_cnt == PERIOD - 1) begin
        if (m_cont && en) begin
          m_cnt = 0; m_nl = int'(n_cycles);
          exp_q.push_back(n_cycles);
        end else begin
          m_run = 0;
        end
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic check_outputs();
    logic [NC_W-1:0] nl_exp;
    check_eq("busy", busy, m_run);
    check_eq("frame_done", frame_done, m_run && m_cnt == PERIOD - 1);
    check_eq("pulse_p", EMA_PULSE_P, m_p);
    check_eq("pulse_n", EMA_PULSE_N, m_n);
    check_eq("on_32", ON_32, m_on);
    check_eq("ctrl_sw", CTRL_SW, m_ctrl);
    check_eq("p_n_overlap", !EMA_PULSE_P && !EMA_PULSE_N, 1'b0);
    if (prev_p === 1'b1 && EMA_PULSE_P === 1'b0) pulse_cnt++;
    prev_p = EMA_PULSE_P;
    if (frame_done === 1'b1) begin
      check_eq("sb_frame_pending", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        nl_exp = exp_q.pop_front();
        check_eq("sb_pulse_pairs", pulse_cnt, nl_exp);
      end
      pulse_cnt = 0;
    end
  endtask

  // driver: check the state left by the last edge, then present inputs for the next edge
  task automatic drive_cycle(input logic r, input logic e, input logic s, input logic t,
                             input int n);
    @(negedge clk_80mhz);
    check_outputs();
    rst = r; en = e; single_shot = s; trig = t; n_cycles = n[NC_W-1:0];
    model_step();
  endtask

  task automatic run_until_cnt(input string tag, input int target, input logic s, input int n);
    int guard = 0;
    while (!(m_run && m_cnt == target) && guard < 600) begin
      drive_cycle(1'b0, 1'b1, s, 1'b0, n);
      guard++;
    end
    check_eq(tag, guard < 600, 1'b1);
  endtask

  initial begin
    logic r_en, r_ss;
    int   r_n;
    rst = 1'b1; en = 1'b0; single_shot = 1'b0; trig = 1'b0; n_cycles = '0;
    model_step();
    repeat (3) drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);

    // continuous, two pairs, two full frames
    repeat (402) drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 2);
    // zero-pair frame, then 2 -> 5 change mid-frame
    repeat (200) drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 0);
    repeat (100) drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 2);
    repeat (300) drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 5);

    // en dropped mid-frame: frame completes, then idle
    run_until_cnt("wait_cnt100", 100, 1'b0, 3);
    repeat (300) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 3);

    // single shot: trig, ignored trig at cnt 60, restart from idle
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 3);
    repeat (60) drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 3);
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1);
    repeat (200) drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1);
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 4);
    repeat (210) drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 4);

    // reset in the middle of a P low phase
    run_until_cnt("wait_cnt55", 55, 1'b0, 2);
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 2);
    repeat (5) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 2);

    // random traffic
    r_en = 1'b1; r_ss = 1'b0; r_n = 2;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0) r_en = !r_en;
      if ($urandom_range(0, 299) == 0) r_ss = !r_ss;
      if ($urandom_range(0, 49) == 0) r_n = $urandom_range(0, 5);
      drive_cycle($urandom_range(0, 799) == 0, r_en, r_ss, $urandom_range(0, 39) == 0, r_n);
    end
    repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
